// File: rtl/matrix_display_arbiter_pkg.sv
// Shared types and constants for the LED matrix display arbiter.
package matrix_pkg;

  localparam int LED_BITS = 128;
  localparam int CNT_W    = 16;

  typedef logic [LED_BITS-1:0] led_pattern_t;

  localparam led_pattern_t BLANK = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } arb_state_t;

  // Counter value loaded on every grant; the owner then spends exactly
  // hold_cycles cycles in HOLD before preemption becomes possible.
  function automatic logic [CNT_W-1:0] hold_load(input int hold_cycles);
    return CNT_W'(hold_cycles - 1);
  endfunction

endpackage

// File: rtl/matrix_display_arbiter_if.sv
// Request/pattern bus between the pattern sources and the display arbiter.
//
// Handshake: req[i] is a level request held by source i for as long as it
// wants the display; grant[i] is the registered answer. A source owns the
// matrix only while both req[i] and grant[i] are high, and dropping req[i]
// releases ownership on the next edge. There is no separate ready: grant
// acts as ready, and pattern_in slice i is only looked at while granted.
interface matrix_display_arbiter_if
  import matrix_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*LED_BITS-1:0] pattern_in;
  logic [NUM_REQ-1:0]          grant;
  led_pattern_t                led_on;
  logic                        owner_valid;
  logic [IDX_W-1:0]            owner_idx;
  logic                        switch_pulse;

  // Sources side: drives requests and patterns, observes ownership.
  modport master (
    output req, pattern_in,
    input  grant, led_on, owner_valid, owner_idx, switch_pulse
  );

  // Arbiter side.
  modport slave (
    input  req, pattern_in,
    output grant, led_on, owner_valid, owner_idx, switch_pulse
  );

endinterface

// File: rtl/matrix_display_arbiter_prio_enc.sv
// Fixed-priority encoder: the lowest set bit of req wins.
module matrix_prio_enc #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // Scan from the top down so the lowest requesting index is written last.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid     = 1'b1;
        idx       = W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_display_arbiter.sv
// Shares one 8x16 LED matrix between prioritised pattern sources. A new
// owner keeps the matrix for HOLD_CYCLES cycles so the driver's SPI burst
// is not torn by a preemption; releases are always honoured at once.
module matrix_display_arbiter
  import matrix_pkg::*;
#(
  parameter int           NUM_REQ       = 4,
  parameter int           HOLD_CYCLES   = 256,
  parameter led_pattern_t BLANK_PATTERN = BLANK
) (
  input  logic                          clk,
  input  logic                          rst,
  matrix_display_arbiter_if.slave       bus,
  output arb_state_t                    state
);

  localparam int              IDX_W     = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] HOLD_LOAD = hold_load(HOLD_CYCLES);

  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_oh;

  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 valid_q;
  logic                 pulse_q;
  led_pattern_t         led_q;
  logic [CNT_W-1:0]     cnt;

  led_pattern_t         pats [NUM_REQ];
  logic                 owner_req;

  matrix_prio_enc #(.N(NUM_REQ)) u_prio_enc (
    .req    (bus.req),
    .valid  (win_valid),
    .idx    (win_idx),
    .onehot (win_oh)
  );

  // Split the packed pattern bus so only the selected slice reaches led_on.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pats[i] = bus.pattern_in[i*LED_BITS +: LED_BITS];
    end
  end

  assign owner_req = bus.req[idx_q];

  // Arbitration FSM with registered grant, index, pulse and pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      led_q   <= BLANK_PATTERN;
      cnt     <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          led_q <= BLANK_PATTERN;
          if (win_valid) begin
            grant_q <= win_oh;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
            led_q   <= pats[win_idx];
            cnt     <= HOLD_LOAD;
            pulse_q <= 1'b1;
            state   <= HOLD;
          end
        end

        HOLD: begin
          if (!owner_req) begin
            // Release beats the HOLD->OPEN step, even when cnt==0.
            pulse_q <= 1'b1;
            if (win_valid) begin
              grant_q <= win_oh;
              idx_q   <= win_idx;
              led_q   <= pats[win_idx];
              cnt     <= HOLD_LOAD;
            end else begin
              grant_q <= '0;
              idx_q   <= '0;
              valid_q <= 1'b0;
              led_q   <= BLANK_PATTERN;
              state   <= IDLE;
            end
          end else begin
            led_q <= pats[idx_q];
            if (cnt == '0) begin
              state <= OPEN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        OPEN: begin
          if (!win_valid) begin
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            led_q   <= BLANK_PATTERN;
            pulse_q <= 1'b1;
            state   <= IDLE;
          end else if (win_idx != idx_q) begin
            // Covers both a higher-priority arrival and an owner drop.
            grant_q <= win_oh;
            idx_q   <= win_idx;
            led_q   <= pats[win_idx];
            cnt     <= HOLD_LOAD;
            pulse_q <= 1'b1;
            state   <= HOLD;
          end else begin
            led_q <= pats[idx_q];
          end
        end

        default: begin
          grant_q <= '0;
          idx_q   <= '0;
          valid_q <= 1'b0;
          led_q   <= BLANK_PATTERN;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.owner_idx    = idx_q;
  assign bus.owner_valid  = valid_q;
  assign bus.switch_pulse = pulse_q;
  assign bus.led_on       = led_q;

endmodule

// File: tb/tb_matrix_display_arbiter.sv
// Directed bench for matrix_display_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
module tb_matrix_display_arbiter;
  import matrix_pkg::*;

  localparam int NR = 4;
  localparam int HC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  arb_state_t state;

  always #5 clk = ~clk;

  matrix_display_arbiter_if #(.NUM_REQ(NR)) bus ();

  matrix_display_arbiter #(
    .NUM_REQ       (NR),
    .HOLD_CYCLES   (HC),
    .BLANK_PATTERN (128'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [127:0] pat_tab [NR];
  logic [127:0] exp_q [$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       pulse;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] ix,
                            input logic v, input logic p, input logic [127:0] led);
    check({tag, ".grant"},  128'(bus.grant),        128'(g));
    check({tag, ".idx"},    128'(bus.owner_idx),    128'(ix));
    check({tag, ".valid"},  128'(bus.owner_valid),  128'(v));
    check({tag, ".pulse"},  128'(bus.switch_pulse), 128'(p));
    check({tag, ".led"},    bus.led_on,             led);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pats();
    for (int i = 0; i < NR; i++) bus.pattern_in[i*128 +: 128] = pat_tab[i];
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] ix,
                              input logic v, input logic p);
    vec_t e;
    e.req = r; e.grant = g; e.idx = ix; e.valid = v; e.pulse = p;
    vecs.push_back(e);
  endfunction

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pat_tab[0] = 128'h0123_4567_89AB_CDEF_0000_0000_0000_0001;
    pat_tab[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    pat_tab[2] = 128'hAAAA_5555;
    pat_tab[3] = 128'hDEAD_BEEF_0000_0000_FFFF_0000_CAFE_F00D;

    rst     = 1'b1;
    bus.req = '0;
    set_pats();

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 128'h0);
    check("reset.state", 128'(state), 128'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0000);
      check("idle.grant", 128'(bus.grant), 128'h0);
      check("idle.pulse", 128'(bus.switch_pulse), 128'h0);
      check("idle.led", bus.led_on, 128'h0);
    end
    // Mid-cycle reset pulse while idle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_outs("idle_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, then drop
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Hold protection: owner 3, req[0] rises on 2nd owned cycle
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);  // HOLD, cnt=3
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);  // cnt=2
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);  // cnt=1
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);  // cnt=0
    add(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);  // -> OPEN
    add(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1);  // preempted
    add(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    // Owner 0 drops in HOLD, req[2] takes over directly
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);  // -> OPEN
    // In OPEN: owner 2 drops and req[1] rises together
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    // Owner drops exactly at cnt==0 while req[3] is up
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);  // cnt=3
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);  // cnt=2
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);  // cnt=1
    add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);  // cnt=0
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);  // release wins, new HOLD
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);  // -> OPEN
    add(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);  // OPEN, same owner
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);  // OPEN -> IDLE
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].req);
      exp_q.push_back(vecs[k].valid ? pat_tab[vecs[k].idx] : 128'h0);
      check_outs($sformatf("vec%0d", k), vecs[k].grant, vecs[k].idx,
                 vecs[k].valid, vecs[k].pulse, exp_q.pop_front());
    end

    // Live pattern update and X on a non-owner
    bus.pattern_in[1*128 +: 128] = 128'h0F;
    step(4'b0010);
    check_outs("live0", 4'b0010, 2'd1, 1'b1, 1'b1, 128'h0F);
    @(negedge clk);
    bus.pattern_in[1*128 +: 128] = 128'hF0;
    @(posedge clk);
    #1;
    check("live1.led", bus.led_on, 128'hF0);
    check("live1.state", 128'(state), 128'(HOLD));
    @(negedge clk);
    bus.pattern_in[3*128 +: 128] = 'x;
    @(posedge clk);
    #1;
    check_outs("live_x", 4'b0010, 2'd1, 1'b1, 1'b0, 128'hF0);
    set_pats();
    step(4'b0000);
    check_outs("live_end", 4'b0000, 2'd0, 1'b0, 1'b1, 128'h0);

    // Reset in cycle 2 of HOLD with all requests up
    step(4'b1111);
    check_outs("rh0", 4'b0001, 2'd0, 1'b1, 1'b1, pat_tab[0]);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_outs("rh_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 128'h0);
    check("rh_rst.state", 128'(state), 128'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outs("rh_after", 4'b0001, 2'd0, 1'b1, 1'b1, pat_tab[0]);
    step(4'b0000);
    check_outs("rh_done", 4'b0000, 2'd0, 1'b0, 1'b1, 128'h0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
